nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit ripple_adder to add WIDTH-bit operands, one nibble per clock.
//  - Carry is chained through a register between nibbles.
//  - Sits between an operand producer and a result consumer.
//  - Both sides use valid/ready handshakes.
//  - Trades area for latency wherever a wide adder is not justified.
// PARAMETERS
//  WIDTH    16           operand/result width; multiple of 4, >= 8
//  NIBBLES  WIDTH/4      localparam, derived; number of RUN cycles per operation
//  CNT_W    $clog2(NIBBLES)  localparam, derived; nibble counter width
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      controller can accept operands (= state==IDLE)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in to nibble 0
//  out_valid  out  1      result present (= state==DONE)
//  out_ready  in   1      consumer takes result
//  out_sum    out  WIDTH  A+B+cin, low WIDTH bits
//  out_cout   out  1      carry out of MSB nibble
//  busy       out  1      state!=IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE; cnt, A/B shift regs, carry reg, out_sum and out_cout all 0.
//  - Takes effect immediately, independent of clk.
//  IDLE:
//  - in_ready=1.
//  - in_valid&&in_ready: load in_a/in_b into shift regs, carry<=in_cin, cnt<=0, go to RUN.
//  RUN (in_ready=0):
//  - Adder inputs: A=a_sh[3:0], B=b_sh[3:0], Cin=carry.
//  - Each edge: a_sh/b_sh shift right by 4; result reg shifts right by 4 with Sum inserted at [WIDTH-1:WIDTH-4]; carry<=Cout; cnt++.
//  - At cnt==NIBBLES-1: out_cout<=Cout, go to DONE.
//  DONE:
//  - out_valid=1; out_sum/out_cout held stable until out_valid&&out_ready.
//  - On that handshake, go to IDLE.
//  Latency and throughput:
//  - out_valid rises NIBBLES edges after the accept edge.
//  - in_ready rises 1 edge after out handshake.
//  - Max throughput: 1 op per NIBBLES+2 cycles.
//  Boundary conditions:
//  - in_valid during RUN/DONE is ignored and not captured. Producer must hold it until accepted.
//  - out_ready with out_valid=0 has no effect.
//  - Same-cycle out_ready in DONE and in_valid: in_valid is not accepted that cycle (in_ready=0).
//  - Full carry ripple (e.g. 0xFFFF+1) resolves over NIBBLES cycles, since only one adder is used.
//  - Reset mid-RUN/DONE aborts: partial result discarded, no out_valid pulse.
//  - out_sum after reset reads 0 until the first completed op, then holds the last result.
//  - Overflow wraps mod 2^WIDTH; the MSB carry is reported only on out_cout.
// STRUCTURE
//  Shared include adder_pkg.vh:
//  - NIBBLE_W=4.
//  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 unreachable -> IDLE).
//  Sub-modules and logic split:
//  - One sub-module: existing ripple_adder (A,B,Cin,Sum,Cout), instantiated once.
//  - FSM, counter, shift regs and carry reg are in this module.
//  - No other hierarchy.
// TESTING (WIDTH=16 unless noted)
//  1. A=0x000B B=0x000F cin=0:
//     -> out_sum=0x001A, out_cout=0; out_valid exactly 4 edges after accept.
//  2. A=0xFFFF B=0x0001 cin=0:
//     -> out_sum=0x0000, out_cout=1 (carry through all nibbles).
//  3. A=0xFFFF B=0xFFFF cin=1:
//     -> out_sum=0xFFFF, out_cout=1.
//  4. Result with out_ready=0 for 5 cycles, new in_valid asserted meanwhile:
//     -> out_valid/out_sum/out_cout stable, in_ready=0, second op not captured;
//     -> after out_ready, second op accepted one cycle later.
//  5. rst_n low during 2nd RUN cycle:
//     -> outputs 0, in_ready=1, no out_valid;
//     -> then 0x1234+0x4321 cin=0 gives 0x5555, cout=0.
//  6. WIDTH=8 and 32, 1000 random ops with random in_valid/out_ready stalls:
//     -> every result equals {cout,sum}=a+b+cin; no ops lost or duplicated.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   NIBBLE_W : datapath slice width handled by the single ripple adder
//   state_t  : controller state encoding
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_ripple_adder.sv
// ripple_adder: combinational NIBBLE_W-bit ripple-carry adder.
// Ports:
//   a, b  in   NIBBLE_W  operands
//   cin   in   1         carry in
//   sum   out  NIBBLE_W  a+b+cin, low bits
//   cout  out  1         carry out of the MSB
module ripple_adder
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // Carry rippled through a block-local variable so no vector feeds back on itself.
  always_comb begin : ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands with one shared
// 4-bit ripple adder, one nibble per clock, carry chained through a register.
// Ports:
//   clk        in   1      clock
//   rst_n      in   1      async active-low reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      ready for operands (IDLE)
//   in_a/in_b  in   WIDTH  operands
//   in_cin     in   1      carry into nibble 0
//   out_valid  out  1      result present (DONE)
//   out_ready  in   1      consumer takes result
//   out_sum    out  WIDTH  last completed sum (mod 2^WIDTH)
//   out_cout   out  1      carry out of the MSB nibble
//   busy       out  1      not IDLE
//
// state   | meaning
// IDLE    | waiting for an operand beat
// RUN     | adding one nibble per cycle, LSB first
// DONE    | result presented, waiting for consumer
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    a_sh, b_sh, res_sh;
  logic                carry;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                last_nib;
  logic [WIDTH-1:0]    res_next;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign last_nib  = (cnt == CNT_LAST);
  assign res_next  = {nib_sum, res_sh[WIDTH-1:NIBBLE_W]};

  ripple_adder u_adder (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_nib)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // out_sum is separate from the working shift register so it keeps the
  // previous result stable while the next operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          res_sh <= res_next;
          carry  <= nib_cout;
          cnt    <= cnt + 1'b1;
          if (last_nib) begin
            out_sum  <= res_next;
            out_cout <= nib_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
